pipe_generator: RTL and testbench

//  Producer side of the collision interface: generates and scrolls green pipe columns across the LED grid.

---
 rtl/flappy_pkg.sv | 19 +
 rtl/pipe_lfsr.sv | 28 ++
 rtl/pipe_generator.sv | 135 +++++++++++++
 tb/tb_pipe_generator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the pipe generator.
// Holds the game-state enum and the LFSR seed/tap positions.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } pg_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Taps for x^8 + x^6 + x^5 + x^4 + 1, as bit indices of the shift register
    localparam int LFSR_TAP_A = 7;
    localparam int LFSR_TAP_B = 5;
    localparam int LFSR_TAP_C = 4;
    localparam int LFSR_TAP_D = 3;

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR that supplies gap positions for new pipes.
// Advances only when adv is high; the seed is non-zero, so the all-zero lock-up state is never reached.
module pipe_lfsr
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    output logic [7:0] q
);

    logic [7:0] lfsr_reg;
    logic       feedback;

    assign feedback = lfsr_reg[LFSR_TAP_A] ^ lfsr_reg[LFSR_TAP_B]
                    ^ lfsr_reg[LFSR_TAP_C] ^ lfsr_reg[LFSR_TAP_D];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else if (adv) begin
            lfsr_reg <= {lfsr_reg[6:0], feedback};
        end
    end

    assign q = lfsr_reg;

endmodule

// File: rtl/pipe_generator.sv
// Generates and scrolls pipe columns across the LED grid and exports the bird column.
// Optional pass counter is built when PIPE_SCORE_EN is defined.
module pipe_generator
    import flappy_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BIRD_COL     = 4,
    parameter int GAP_SIZE     = 3,
    parameter int PIPE_SPACING = 4,
    parameter int STEP_CYCLES  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 lose,
`ifdef PIPE_SCORE_EN
    input  logic                 pass,
    output logic [7:0]           score,
`endif
    output logic [COLS*ROWS-1:0] green_array,
    output logic [ROWS-1:0]      green_position,
    output logic                 spawn
);

    localparam int STEP_W  = $clog2(STEP_CYCLES);
    localparam int SPACE_W = $clog2(PIPE_SPACING);
    localparam int IDX_W   = $clog2(ROWS);
    localparam int GAP_MAX = ROWS - GAP_SIZE;

    pg_state_t           state_reg, state_next;
    logic [STEP_W-1:0]   step_cnt_reg;
    logic [SPACE_W-1:0]  space_cnt_reg;
    logic [7:0]          lfsr_q;
    logic                strobe;
    logic                advance;
    logic [IDX_W-1:0]    idx;
    int                  gap_row;
    logic [ROWS-1:0]     pipe_mask;
    logic [ROWS-1:0]     new_col;
    logic [COLS*ROWS-1:0] shifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (lose)  state_next = FROZEN;
            FROZEN:  state_next = FROZEN;
            default: state_next = IDLE;
        endcase
    end

    assign strobe  = (state_reg == RUN) && (step_cnt_reg == STEP_W'(STEP_CYCLES - 1));
    // A coincident lose suppresses the whole step: no shift, spawn or LFSR advance
    assign advance = strobe && !lose;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt_reg <= '0;
        end else if (state_reg == RUN && !lose) begin
            step_cnt_reg <= strobe ? '0 : step_cnt_reg + 1'b1;
        end
    end

    pipe_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (advance),
        .q     (lfsr_q)
    );

    // Out-of-range indices fold back so the gap always fits inside the column
    assign idx = lfsr_q[IDX_W-1:0];
    always_comb begin
        gap_row = int'(idx);
        if (int'(idx) > GAP_MAX) begin
            gap_row = int'(idx) - (GAP_MAX + 1);
        end
    end

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_mask
            assign pipe_mask[gi] = !((gi >= gap_row) && (gi < gap_row + GAP_SIZE));
        end
    endgenerate

    assign new_col = (space_cnt_reg == '0) ? pipe_mask : '0;
    assign shifted = {new_col, green_array[COLS*ROWS-1:ROWS]};

    always_ff @(posedge clk) begin
        if (reset) begin
            green_array    <= '0;
            green_position <= '0;
            space_cnt_reg  <= '0;
            spawn          <= 1'b0;
        end else begin
            spawn <= 1'b0;
            if (advance) begin
                green_array    <= shifted;
                green_position <= shifted[BIRD_COL*ROWS +: ROWS];
                spawn          <= (space_cnt_reg == '0);
                space_cnt_reg  <= (space_cnt_reg == '0) ? SPACE_W'(PIPE_SPACING - 1)
                                                        : space_cnt_reg - 1'b1;
            end
        end
    end

`ifdef PIPE_SCORE_EN
    logic       pass_d_reg;
    logic [7:0] score_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pass_d_reg <= 1'b0;
            score_reg  <= '0;
        end else begin
            pass_d_reg <= pass;
            if (state_reg == RUN && pass && !pass_d_reg && score_reg != 8'hFF) begin
                score_reg <= score_reg + 1'b1;
            end
        end
    end

    assign score = score_reg;
`endif

endmodule

// File: tb/tb_pipe_generator.sv
// Randomized scoreboard bench for pipe_generator against a column-list game model.
// Define PIPE_SCORE_EN to also check the pass counter.
module tb_pipe_generator;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int BIRD_COL = 4;
    localparam int GAP = 3;
    localparam int SPACING = 4;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        lose = 1'b0;
    logic        pass_i = 1'b0;
    logic [7:0]  score_o;
    logic [63:0] green_array;
    logic [7:0]  green_position;
    logic        spawn;

    always #5 clk = ~clk;

    pipe_generator #(
        .ROWS(ROWS), .COLS(COLS), .BIRD_COL(BIRD_COL), .GAP_SIZE(GAP),
        .PIPE_SPACING(SPACING), .STEP_CYCLES(STEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .lose           (lose),
`ifdef PIPE_SCORE_EN
        .pass           (pass_i),
        .score          (score_o),
`endif
        .green_array    (green_array),
        .green_position (green_position),
        .spawn          (spawn)
    );

`ifndef PIPE_SCORE_EN
    assign score_o = 8'h00;
`endif

    typedef struct {
        logic [63:0] arr;
        logic [7:0]  pos;
        logic        spw;
        logic [7:0]  scr;
        logic        upd;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Game model: 0 idle, 1 running, 2 frozen
    int         m_st = 0;
    int         m_run = 0;
    int         m_space = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_cols[COLS];
    logic       m_spawn = 1'b0;
    logic [7:0] m_score = 8'h00;
    logic       m_pass_d = 1'b0;

    function automatic logic [7:0] gap_mask(input logic [7:0] l);
        int idx = int'(l) % ROWS;
        int g = (idx > ROWS - GAP) ? idx - (ROWS - GAP) - 1 : idx;
        logic [7:0] m = 8'hFF;
        for (int k = 0; k < GAP; k++) m[g + k] = 1'b0;
        return m;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic next_is_strobe();
        return (m_st == 1) && (m_run % STEP == STEP - 1);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic l, input logic p);
        exp_t e;
        e.upd = 1'b0;
        if (r) begin
            m_st = 0; m_run = 0; m_space = 0; m_lfsr = 8'hA5;
            for (int c = 0; c < COLS; c++) m_cols[c] = 8'h00;
            m_spawn = 1'b0; m_score = 8'h00; m_pass_d = 1'b0;
        end else begin
            if (m_st == 1 && p && !m_pass_d && m_score != 8'hFF) m_score = m_score + 8'd1;
            m_pass_d = p;
            m_spawn = 1'b0;
            case (m_st)
                0: if (s) begin m_st = 1; m_run = 0; end
                1: begin
                    if (l) begin
                        m_st = 2;
                    end else begin
                        if (m_run % STEP == STEP - 1) begin
                            for (int c = 0; c < COLS - 1; c++) m_cols[c] = m_cols[c + 1];
                            if (m_space == 0) begin
                                m_cols[COLS - 1] = gap_mask(m_lfsr);
                                m_spawn = 1'b1;
                                m_space = SPACING - 1;
                            end else begin
                                m_cols[COLS - 1] = 8'h00;
                                m_space--;
                            end
                            m_lfsr = lfsr_next(m_lfsr);
                            e.upd = 1'b1;
                        end
                        m_run++;
                    end
                end
                default: ;
            endcase
        end
        for (int c = 0; c < COLS; c++) e.arr[c*ROWS +: ROWS] = m_cols[c];
        e.pos = m_cols[BIRD_COL];
        e.spw = m_spawn;
        e.scr = m_score;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic s, input logic l, input logic p);
        @(negedge clk);
        reset = r; start = s; lose = l; pass_i = p;
        model_step(r, s, l, p);
    endtask

    // Monitor: the DUT presents a fresh output set after every rising edge
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                bad = 1'b0;
                if (green_array !== e.arr) begin
                    $display("FAIL green_array t=%0t got=%h exp=%h", $time, green_array, e.arr);
                    bad = 1'b1;
                end
                if (green_position !== e.pos) begin
                    $display("FAIL green_position t=%0t got=%h exp=%h", $time, green_position, e.pos);
                    bad = 1'b1;
                end
                if (spawn !== e.spw) begin
                    $display("FAIL spawn t=%0t got=%b exp=%b", $time, spawn, e.spw);
                    bad = 1'b1;
                end
`ifdef PIPE_SCORE_EN
                if (score_o !== e.scr) begin
                    $display("FAIL score t=%0t got=%0d exp=%0d", $time, score_o, e.scr);
                    bad = 1'b1;
                end
`endif
                if (bad) miscompares++;
                if (e.upd)
                    $display("step t=%0t array=%h pos=%h spawn=%b score=%0d", $time,
                             green_array, green_position, spawn, score_o);
            end
        end
    end

    initial begin
        logic l, p;
        int run_len;
        for (int c = 0; c < COLS; c++) m_cols[c] = 8'h00;

        // Reset, then idle with start low
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, $urandom_range(0, 1), 0);

        for (int ep = 0; ep < 10; ep++) begin
            drive(0, 1, 0, 0);
            run_len = $urandom_range(20, 160);
            for (int i = 0; i < run_len; i++) begin
                l = ($urandom_range(0, 199) == 0);
                p = ($urandom_range(0, 2) == 0);
                drive(0, $urandom_range(0, 1), l, p);
            end
            if (ep % 2 == 0) begin
                // Lose coincident with a step strobe, then hold frozen with start high
                for (int i = 0; i < STEP && !next_is_strobe(); i++) drive(0, 1, 0, 0);
                drive(0, 1, 1, 0);
                for (int i = 0; i < 20; i++) drive(0, 1, 0, (i % 4) < 2);
            end
            // One-cycle reset mid-game, short idle, restart next episode
            drive(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            for (int i = 0; i < $urandom_range(0, 6); i++) drive(0, 0, 0, 0);
        end

        // Long run with many pass edges to reach score saturation
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 600; i++) drive(0, 0, 0, i[0]);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, i[1]);

        drive(0, 0, 0, 0);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
